// File: rtl/rate_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : rate_tick_gen
//  Description : Button-selectable clock-enable generator. It produces a
//                1-cycle tick and a near-50% square wave at one of NUM_RATES
//                rates. Rate i has a period of BASE_PERIOD >> i clk cycles.
//                The buttons are synchronised, debounced and edge-detected
//                on clk, so no derived or gated clocks are needed.
//  Revision    : 1.0 - initial release
// ============================================================================
module rate_tick_gen #(
  parameter int unsigned CNT_W           = 30,
  parameter int unsigned NUM_RATES       = 9,
  parameter int unsigned BASE_PERIOD     = 500000000,
  parameter int unsigned DEFAULT_IDX     = 0,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic [3:0]                   btn,
  output logic [$clog2(NUM_RATES)-1:0] rate_idx,
  output logic                         tick,
  output logic                         sq_out,
  output logic                         rate_changed
);

  localparam int unsigned c_idx_w = $clog2(NUM_RATES);
  localparam int unsigned c_db_w  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [c_db_w-1:0]  c_db_last = c_db_w'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_idx_w-1:0] c_idx_rst = c_idx_w'(DEFAULT_IDX);
  localparam logic [c_idx_w-1:0] c_idx_max = c_idx_w'(NUM_RATES - 1);
  localparam logic [c_idx_w-1:0] c_idx_nm2 = c_idx_w'(NUM_RATES - 2);
  localparam logic [c_idx_w-1:0] c_idx_one = c_idx_w'(1);
  localparam logic [c_idx_w-1:0] c_idx_two = c_idx_w'(2);
  localparam logic [CNT_W-1:0]   c_base    = CNT_W'(BASE_PERIOD);
  localparam logic [CNT_W-1:0]   c_cnt_one = CNT_W'(1);

  // Decoded rate step requested by the highest-priority press this cycle.
  typedef enum logic [2:0] {
    STEP_NONE = 3'd0,
    STEP_M2   = 3'd1,
    STEP_M1   = 3'd2,
    STEP_P1   = 3'd3,
    STEP_P2   = 3'd4
  } step_e;

  // --------------------------------------------------------------------------
  // Button synchronisers
  // --------------------------------------------------------------------------
  logic [3:0] sync1_q;
  logic [3:0] sync2_q;

  // Two-flop synchroniser for the asynchronous button inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

  // --------------------------------------------------------------------------
  // Per-button debounce: the accepted level follows the synced input only
  // after DEBOUNCE_CYCLES consecutive differing samples. Any agreeing sample
  // clears the count, so a short glitch leaves no partial progress behind.
  // --------------------------------------------------------------------------
  logic [3:0] level_w;

  for (genvar b = 0; b < 4; b++) begin : g_btn
    logic [c_db_w-1:0] db_cnt_q;
    logic [c_db_w-1:0] db_cnt_d;
    logic              lvl_q;
    logic              lvl_d;

    // Count consecutive mismatching samples; flip the level on the last one.
    always_comb begin
      db_cnt_d = '0;
      lvl_d    = lvl_q;
      if (sync2_q[b] != lvl_q) begin
        if (db_cnt_q == c_db_last) begin
          lvl_d = sync2_q[b];
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
    end

    // Debounce counter and accepted level registers.
    always_ff @(posedge clk) begin
      if (reset) begin
        db_cnt_q <= '0;
        lvl_q    <= 1'b0;
      end else begin
        db_cnt_q <= db_cnt_d;
        lvl_q    <= lvl_d;
      end
    end

    assign level_w[b] = lvl_q;
  end

  // --------------------------------------------------------------------------
  // Press detection and rate stepping
  // --------------------------------------------------------------------------
  logic [3:0]         level_prev_q;
  logic [3:0]         press_w;
  step_e              step_w;
  logic [c_idx_w-1:0] rate_idx_q;
  logic [c_idx_w-1:0] rate_idx_d;
  logic               rate_changed_q;
  logic               rate_changed_d;

  // Previous debounced level, used to find rising edges (presses). Because it
  // clears to 0, a button held through reset is seen as a fresh press.
  always_ff @(posedge clk) begin
    if (reset) begin
      level_prev_q <= '0;
    end else begin
      level_prev_q <= level_w;
    end
  end

  assign press_w = level_w & ~level_prev_q;

  // Fixed priority: a press on a higher button hides simultaneous lower ones.
  always_comb begin
    step_w = STEP_NONE;
    if (press_w[3]) begin
      step_w = STEP_M2;
    end else if (press_w[2]) begin
      step_w = STEP_M1;
    end else if (press_w[1]) begin
      step_w = STEP_P1;
    end else if (press_w[0]) begin
      step_w = STEP_P2;
    end
  end

  // Modular index update. Each branch stays within c_idx_w bits, so the
  // arithmetic cannot overflow even when NUM_RATES is a power of two.
  always_comb begin
    rate_idx_d     = rate_idx_q;
    rate_changed_d = 1'b1;
    unique case (step_w)
      STEP_M2: rate_idx_d = (rate_idx_q < c_idx_two) ? rate_idx_q + c_idx_nm2
                                                     : rate_idx_q - c_idx_two;
      STEP_M1: rate_idx_d = (rate_idx_q == '0) ? c_idx_max
                                               : rate_idx_q - c_idx_one;
      STEP_P1: rate_idx_d = (rate_idx_q == c_idx_max) ? '0
                                                      : rate_idx_q + c_idx_one;
      STEP_P2: rate_idx_d = (rate_idx_q >= c_idx_nm2) ? rate_idx_q - c_idx_nm2
                                                      : rate_idx_q + c_idx_two;
      default: rate_changed_d = 1'b0;
    endcase
  end

  // Rate index register and its one-cycle change strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      rate_idx_q     <= c_idx_rst;
      rate_changed_q <= 1'b0;
    end else begin
      rate_idx_q     <= rate_idx_d;
      rate_changed_q <= rate_changed_d;
    end
  end

  // --------------------------------------------------------------------------
  // Period counter, tick and square wave
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] period_w;
  logic [CNT_W-1:0] half_w;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             tick_q;
  logic             tick_d;
  logic             sq_q;
  logic             sq_d;

  assign period_w = c_base >> rate_idx_q;
  assign half_w   = period_w >> 1;

  // A rate change restarts the period from zero and suppresses any pending
  // tick of the old rate. The square wave is derived from the pre-advance
  // count, so it is low for floor(P/2) cycles and then high for ceil(P/2)
  // cycles, and its final high cycle coincides with the tick.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    sq_d   = sq_q;
    if (rate_changed_d) begin
      cnt_d = '0;
      sq_d  = 1'b0;
    end else if (en) begin
      if (cnt_q == period_w - c_cnt_one) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + c_cnt_one;
      end
      sq_d = (cnt_q >= half_w);
    end
  end

  // Counter and registered tick/square outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
      sq_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      sq_q   <= sq_d;
    end
  end

  assign rate_idx     = rate_idx_q;
  assign tick         = tick_q;
  assign sq_out       = sq_q;
  assign rate_changed = rate_changed_q;

endmodule
`default_nettype wire

// File: tb/tb_rate_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rate_tick_gen
//  Description : Directed self-checking bench for rate_tick_gen with
//                BASE_PERIOD=512, NUM_RATES=9, DEBOUNCE_CYCLES=4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rate_tick_gen;

  localparam int unsigned NR = 9;
  localparam int unsigned BP = 512;
  localparam int unsigned DB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [3:0] btn;
  logic [3:0] rate_idx;
  logic       tick;
  logic       sq_out;
  logic       rate_changed;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rate_tick_gen #(
    .CNT_W          (30),
    .NUM_RATES      (NR),
    .BASE_PERIOD    (BP),
    .DEFAULT_IDX    (0),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .btn         (btn),
    .rate_idx    (rate_idx),
    .tick        (tick),
    .sq_out      (sq_out),
    .rate_changed(rate_changed)
  );

  // Advance n rising edges; inputs are driven and outputs sampled at negedge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    en    = 1'b1;
    btn   = 4'b0000;
    cyc(3);
    reset = 1'b0;
  endtask

  // Hold one button long enough to debounce, release it, let release settle.
  task automatic press(input int b);
    btn[b] = 1'b1;
    cyc(10);
    btn[b] = 1'b0;
    cyc(10);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    en    = 1'b1;
    btn   = 4'b0000;
    cyc(3);
    total++; if (rate_idx !== 4'd0) begin bad++; $display("FAIL reset_idx got=%0d exp=0", rate_idx); end
    total++; if (tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b exp=0", tick); end
    total++; if (sq_out !== 1'b0) begin bad++; $display("FAIL reset_sq got=%b exp=0", sq_out); end
    total++; if (rate_changed !== 1'b0) begin bad++; $display("FAIL reset_rc got=%b exp=0", rate_changed); end
    // Button held through reset: counts as a new press after release.
    btn[1] = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(6);
    total++; if (rate_idx !== 4'd0) begin bad++; $display("FAIL held_rst_early got=%0d exp=0", rate_idx); end
    cyc(1);
    total++; if (rate_idx !== 4'd1 || rate_changed !== 1'b1) begin
      bad++; $display("FAIL held_rst_press idx=%0d rc=%b exp idx=1 rc=1", rate_idx, rate_changed);
    end
    btn = 4'b0000;
    cyc(10);
  endtask

  task automatic test_base_period();
    int errs;
    int first;
    errs  = 0;
    first = -1;
    do_reset();
    for (int k = 1; k <= 1024; k++) begin
      cyc(1);
      if (tick !== ((k % 512) == 0) || sq_out !== (((k - 1) % 512) >= 256)) begin
        errs++;
        if (first < 0) first = k;
      end
    end
    total++; if (errs !== 0) begin
      bad++; $display("FAIL base_pattern errors=%0d first_edge=%0d exp errors=0", errs, first);
    end
    total++; if (rate_idx !== 4'd0) begin bad++; $display("FAIL base_idx got=%0d exp=0", rate_idx); end
  endtask

  task automatic test_step_up();
    int errs;
    errs = 0;
    do_reset();
    btn[1] = 1'b1;
    cyc(6);
    total++; if (rate_idx !== 4'd0 || rate_changed !== 1'b0) begin
      bad++; $display("FAIL up_edge6 idx=%0d rc=%b exp idx=0 rc=0", rate_idx, rate_changed);
    end
    cyc(1);
    total++; if (rate_idx !== 4'd1 || rate_changed !== 1'b1 || tick !== 1'b0 || sq_out !== 1'b0) begin
      bad++; $display("FAIL up_edge7 idx=%0d rc=%b tick=%b sq=%b exp 1 1 0 0", rate_idx, rate_changed, tick, sq_out);
    end
    for (int k = 1; k <= 512; k++) begin
      cyc(1);
      if (k == 3) btn[1] = 1'b0;
      if (k == 1 && rate_changed !== 1'b0) errs++;
      if (tick !== ((k % 256) == 0) || sq_out !== (((k - 1) % 256) >= 128) || rate_idx !== 4'd1) errs++;
    end
    total++; if (errs !== 0) begin bad++; $display("FAIL up_period256 errors=%0d exp=0", errs); end
    press(2);
    press(2);
    total++; if (rate_idx !== 4'd8) begin bad++; $display("FAIL down_to8 got=%0d exp=8", rate_idx); end
    press(1);
    total++; if (rate_idx !== 4'd0) begin bad++; $display("FAIL wrap_8_plus1 got=%0d exp=0", rate_idx); end
  endtask

  task automatic test_wrap();
    int ticks;
    ticks = 0;
    press(3);
    total++; if (rate_idx !== 4'd7) begin bad++; $display("FAIL wrap_0_minus2 got=%0d exp=7", rate_idx); end
    for (int k = 0; k < 16; k++) begin
      cyc(1);
      if (tick === 1'b1) ticks++;
    end
    total++; if (ticks !== 4) begin bad++; $display("FAIL period4_ticks got=%0d exp=4", ticks); end
    press(1);
    press(0);
    total++; if (rate_idx !== 4'd1) begin bad++; $display("FAIL wrap_8_plus2 got=%0d exp=1", rate_idx); end
    press(2);
    press(2);
    total++; if (rate_idx !== 4'd8) begin bad++; $display("FAIL wrap_0_minus1 got=%0d exp=8", rate_idx); end
  endtask

  task automatic test_glitch_and_priority();
    int pulses;
    pulses = 0;
    btn[2] = 1'b1;
    cyc(3);
    btn[2] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      cyc(1);
      if (rate_changed === 1'b1) pulses++;
    end
    total++; if (rate_idx !== 4'd8 || pulses !== 0) begin
      bad++; $display("FAIL short_glitch idx=%0d pulses=%0d exp idx=8 pulses=0", rate_idx, pulses);
    end
    btn = 4'b0110;
    for (int k = 0; k < 20; k++) begin
      cyc(1);
      if (k == 9) btn = 4'b0000;
      if (rate_changed === 1'b1) pulses++;
    end
    total++; if (rate_idx !== 4'd7 || pulses !== 1) begin
      bad++; $display("FAIL same_cycle_prio idx=%0d pulses=%0d exp idx=7 pulses=1", rate_idx, pulses);
    end
  endtask

  task automatic test_pause_and_reset();
    int errs;
    int found;
    errs  = 0;
    found = -1;
    do_reset();
    cyc(100);
    en = 1'b0;
    for (int k = 0; k < 50; k++) begin
      cyc(1);
      if (tick !== 1'b0 || sq_out !== 1'b0) errs++;
    end
    total++; if (errs !== 0) begin bad++; $display("FAIL pause_hold errors=%0d exp=0", errs); end
    en = 1'b1;
    for (int k = 1; k <= 600 && found < 0; k++) begin
      cyc(1);
      if (tick === 1'b1) found = k;
    end
    total++; if (found !== 412) begin bad++; $display("FAIL resume_tick got=%0d exp=412", found); end
    cyc(300);
    total++; if (sq_out !== 1'b1) begin bad++; $display("FAIL mid_sq got=%b exp=1", sq_out); end
    btn[1] = 1'b1;
    cyc(3);
    reset = 1'b1;
    cyc(1);
    total++; if (rate_idx !== 4'd0 || tick !== 1'b0 || sq_out !== 1'b0 || rate_changed !== 1'b0) begin
      bad++; $display("FAIL mid_reset idx=%0d tick=%b sq=%b rc=%b exp all 0", rate_idx, tick, sq_out, rate_changed);
    end
    btn = 4'b0000;
    cyc(1);
    reset = 1'b0;
    cyc(20);
    total++; if (rate_idx !== 4'd0) begin bad++; $display("FAIL partial_press got=%0d exp=0", rate_idx); end
  endtask

  task automatic test_fastest();
    int errs;
    logic exp_v;
    errs = 0;
    press(2);
    total++; if (rate_idx !== 4'd8) begin bad++; $display("FAIL fast_idx got=%0d exp=8", rate_idx); end
    // Update edge was 13 edges ago; the next edge completes a period.
    exp_v = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      if (sq_out !== exp_v || tick !== exp_v) errs++;
      exp_v = ~exp_v;
    end
    total++; if (errs !== 0) begin bad++; $display("FAIL fast_pattern errors=%0d exp=0", errs); end
  endtask

  initial begin
    reset = 1'b1;
    en    = 1'b1;
    btn   = 4'b0000;
    test_reset();
    test_base_period();
    test_step_up();
    test_wrap();
    test_glitch_and_priority();
    test_pause_and_reset();
    test_fastest();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
